// File: rtl/rcu_pipelined_multi.sv
// Registered multi-channel route computation unit for one 3D-mesh router.
// Routes are computed on head flits, latched per channel, and reused up to the tail.
package rcu_pkg;
  localparam int MESH_X = 4;
  localparam int MESH_Y = 4;
  localparam int MESH_Z = 4;
  localparam int XW = $clog2(MESH_X);
  localparam int YW = $clog2(MESH_Y);
  localparam int ZW = $clog2(MESH_Z);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } position_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    WEST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4,
    UP    = 3'd5,
    DOWN  = 3'd6,
    DROP  = 3'd7
  } port_t;
endpackage

// Channel FSM states:
//   state  | meaning
//   S_IDLE | waiting for a head flit; non-head flits are dropped and flagged
//   S_BUSY | packet in flight; body/tail flits reuse the latched port
module rcu_pipelined_multi
  import rcu_pkg::*;
#(
  parameter position_t        THIS_POS   = '{x: '0, y: '0, z: '0},
  parameter int               N_IN       = 7,
  parameter port_t [N_IN-1:0] IN_PORT    = '{DOWN, UP, SOUTH, NORTH, WEST, EAST, LOCAL},
  parameter int               FAULT_HOLD = 4,
  parameter logic [15:0]      LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN-1:0]       in_head,
  input  logic [N_IN-1:0]       in_tail,
  input  position_t [N_IN-1:0]  in_dest,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  up_faulty,
  input  logic                  down_faulty,
  output logic [N_IN-1:0]       rt_valid,
  output port_t [N_IN-1:0]      rt_port,
  output logic [N_IN-1:0]       rt_tail,
  input  logic [N_IN-1:0]       rt_ready,
  output logic [N_IN-1:0]       rt_err
);

  typedef enum logic {S_IDLE, S_BUSY} ch_state_t;

  localparam int CW = $clog2(FAULT_HOLD) + 1;

  // Which planar neighbours exist is fixed by the router position.
  localparam bit HAS_E = int'(THIS_POS.x) < MESH_X - 1;
  localparam bit HAS_W = int'(THIS_POS.x) > 0;
  localparam bit HAS_N = int'(THIS_POS.y) < MESH_Y - 1;
  localparam bit HAS_S = int'(THIS_POS.y) > 0;

  ch_state_t          state_q [N_IN];
  port_t [N_IN-1:0]   port_lat_q;
  port_t [N_IN-1:0]   rt_port_q;
  logic  [N_IN-1:0]   rt_valid_q;
  logic  [N_IN-1:0]   rt_tail_q;
  logic  [N_IN-1:0]   rt_err_q;
  port_t [N_IN-1:0]   route_d;

  logic [1:0]         fault_raw;
  logic [1:0]         fault_q;
  logic [CW-1:0]      fcnt_q [2];
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;

  assign in_ready = ~rt_valid_q | rt_ready;
  assign rt_valid = rt_valid_q;
  assign rt_port  = rt_port_q;
  assign rt_tail  = rt_tail_q;
  assign rt_err   = rt_err_q;

  function automatic port_t detour_fn(input port_t inport);
    port_t p;
    if (HAS_E && inport != EAST)       p = EAST;
    else if (HAS_W && inport != WEST)  p = WEST;
    else if (HAS_N && inport != NORTH) p = NORTH;
    else if (HAS_S && inport != SOUTH) p = SOUTH;
    else                               p = DROP;
    return p;
  endfunction

  function automatic port_t route_fn(input position_t dest, input logic pick_y,
                                     input port_t inport, input logic up_f,
                                     input logic dn_f);
    logic [XW:0] hx;
    logic [YW:0] hy;
    logic [ZW:0] hz;
    logic        x_go, y_go, z_pos, z_neg, v_fault;
    port_t       x_port, y_port, p;
    hx     = {1'b0, dest.x} - {1'b0, THIS_POS.x};
    hy     = {1'b0, dest.y} - {1'b0, THIS_POS.y};
    hz     = {1'b0, dest.z} - {1'b0, THIS_POS.z};
    x_go   = (hx != '0);
    y_go   = (hy != '0);
    z_neg  = hz[ZW];
    z_pos  = !hz[ZW] && (hz != '0);
    x_port = hx[XW] ? WEST : EAST;
    y_port = hy[YW] ? SOUTH : NORTH;
    v_fault = z_pos ? up_f : dn_f;
    if (z_pos || z_neg) begin
      if (!v_fault)          p = z_pos ? UP : DOWN;
      else if (x_go && y_go) p = pick_y ? y_port : x_port;
      else if (x_go)         p = x_port;
      else if (y_go)         p = y_port;
      else                   p = detour_fn(inport);
    end else if (x_go) begin
      p = x_port;
    end else if (y_go) begin
      p = y_port;
    end else begin
      p = LOCAL;
    end
    return p;
  endfunction

  always_comb begin
    route_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      route_d[i] = route_fn(in_dest[i], lfsr_q[i], IN_PORT[i], fault_q[0], fault_q[1]);
    end
  end

  // Galois form, right-shifting; the tap mask covers x^16, x^14, x^13, x^11.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign fault_raw = {down_faulty, up_faulty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      for (int k = 0; k < 2; k++) fcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (fault_raw[k] == fault_q[k]) begin
          fcnt_q[k] <= '0;
        end else if (fcnt_q[k] == CW'(FAULT_HOLD - 1)) begin
          fault_q[k] <= fault_raw[k];
          fcnt_q[k]  <= '0;
        end else begin
          fcnt_q[k] <= fcnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_valid_q <= '0;
      rt_tail_q  <= '0;
      rt_err_q   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        state_q[i]    <= S_IDLE;
        rt_port_q[i]  <= DROP;
        port_lat_q[i] <= DROP;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          rt_valid_q[i] <= 1'b1;
          rt_tail_q[i]  <= in_tail[i];
          if (in_head[i]) begin
            rt_port_q[i]  <= route_d[i];
            port_lat_q[i] <= route_d[i];
            if (state_q[i] == S_BUSY) rt_err_q[i] <= 1'b1;
            state_q[i] <= in_tail[i] ? S_IDLE : S_BUSY;
          end else if (state_q[i] == S_IDLE) begin
            rt_port_q[i] <= DROP;
            rt_err_q[i]  <= 1'b1;
          end else begin
            rt_port_q[i] <= port_lat_q[i];
            if (in_tail[i]) state_q[i] <= S_IDLE;
          end
        end else if (rt_ready[i]) begin
          rt_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcu_pipelined_multi.sv
// Scoreboard bench for rcu_pipelined_multi at router (1,1,1) in a 4x4x4 mesh.
module tb_rcu_pipelined_multi;
  import rcu_pkg::*;

  localparam int N = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_head = '0;
  logic [N-1:0]      in_tail = '0;
  position_t [N-1:0] in_dest = '0;
  logic [N-1:0]      in_ready;
  logic              up_faulty = 1'b0;
  logic              down_faulty = 1'b0;
  logic [N-1:0]      rt_valid;
  port_t [N-1:0]     rt_port;
  logic [N-1:0]      rt_tail;
  logic [N-1:0]      rt_ready = '1;
  logic [N-1:0]      rt_err;

  rcu_pipelined_multi #(
    .THIS_POS   ('{x: 2'd1, y: 2'd1, z: 2'd1}),
    .N_IN       (N),
    .FAULT_HOLD (4),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_head     (in_head),
    .in_tail     (in_tail),
    .in_dest     (in_dest),
    .in_ready    (in_ready),
    .up_faulty   (up_faulty),
    .down_faulty (down_faulty),
    .rt_valid    (rt_valid),
    .rt_port     (rt_port),
    .rt_tail     (rt_tail),
    .rt_ready    (rt_ready),
    .rt_err      (rt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    ch;
    port_t port;
    logic  tail;
    logic  err;
  } exp_t;

  exp_t         sb[$];
  int           tests_run = 0;
  int           failed = 0;
  logic [N-1:0] err_model = '0;
  logic [15:0]  m_lfsr;
  logic         count_en = 1'b0;
  int           east_cnt = 0;
  int           north_cnt = 0;

  // Reference LFSR from the polynomial definition, used to predict adaptive picks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic position_t pos(input int x, input int y, input int z);
    position_t p;
    p.x = 2'(x);
    p.y = 2'(y);
    p.z = 2'(z);
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int ch, input logic h, input logic t, input position_t d,
                      input port_t ep, input logic eerr);
    int   waitc;
    exp_t e;
    waitc = 0;
    in_valid[ch] = 1'b1;
    in_head[ch]  = h;
    in_tail[ch]  = t;
    in_dest[ch]  = d;
    #1;
    while (!in_ready[ch] && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready[ch]) begin
      tests_run++;
      failed++;
      $display("FAIL accept_timeout ch%0d: in_ready=0, expected 1 within 20 cycles", ch);
    end else begin
      err_model[ch] = err_model[ch] | eerr;
      e.ch   = ch;
      e.port = ep;
      e.tail = t;
      e.err  = err_model[ch];
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid[ch] = 1'b0;
    in_head[ch]  = 1'b0;
    in_tail[ch]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk(name, sb.size(), 0);
  endtask

  // Monitor: a result presented with rt_ready high is consumed on the next edge.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (rt_valid[i] && rt_ready[i]) begin
            idx = -1;
            for (int k = 0; k < sb.size(); k++) begin
              if (sb[k].ch == i) begin
                idx = k;
                break;
              end
            end
            tests_run++;
            if (idx < 0) begin
              failed++;
              $display("FAIL unexpected_result ch%0d: got port=%0d, expected no result", i, rt_port[i]);
            end else begin
              if (rt_port[i] != sb[idx].port || rt_tail[i] != sb[idx].tail ||
                  rt_err[i] != sb[idx].err) begin
                failed++;
                $display("FAIL route ch%0d: got port=%0d tail=%0b err=%0b, expected port=%0d tail=%0b err=%0b",
                         i, rt_port[i], rt_tail[i], rt_err[i], sb[idx].port, sb[idx].tail, sb[idx].err);
              end
              if (count_en && i == 2) begin
                if (rt_port[i] == EAST)       east_cnt++;
                else if (rt_port[i] == NORTH) north_cnt++;
              end
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    port_t ep;
    repeat (2) @(negedge clk);
    chk("reset_rt_valid", int'(rt_valid), 0);
    chk("reset_rt_err", int'(rt_err), 0);
    chk("reset_in_ready", int'(in_ready), 7'h7f);
    for (int i = 0; i < N; i++) chk("reset_rt_port", int'(rt_port[i]), int'(DROP));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dimension-order routing and per-channel FSM.
    send(2, 1, 1, pos(3, 1, 1), EAST,  0);
    send(2, 1, 1, pos(1, 1, 1), LOCAL, 0);
    send(1, 1, 1, pos(0, 2, 1), WEST,  0);
    send(3, 1, 1, pos(1, 0, 1), SOUTH, 0);
    send(3, 1, 1, pos(1, 3, 1), NORTH, 0);
    send(4, 1, 0, pos(1, 1, 2), UP,    0);
    send(4, 0, 0, pos(3, 1, 1), UP,    0);
    send(4, 0, 1, pos(3, 1, 1), UP,    0);
    send(4, 1, 1, pos(3, 3, 1), EAST,  0);
    send(0, 0, 1, pos(3, 1, 1), DROP,  1);
    send(6, 1, 0, pos(1, 0, 1), SOUTH, 0);
    send(6, 1, 1, pos(3, 1, 1), EAST,  1);
    send(6, 1, 1, pos(1, 1, 0), DOWN,  0);
    drain("drain_basic");

    // Down fault rising mid-packet leaves the latched route alone.
    send(5, 1, 0, pos(1, 1, 0), DOWN, 0);
    send(5, 0, 0, pos(3, 3, 3), DOWN, 0);
    down_faulty = 1'b1;
    idle(5);
    send(5, 0, 0, pos(3, 3, 3), DOWN, 0);
    send(5, 0, 0, pos(3, 3, 3), DOWN, 0);
    send(5, 0, 1, pos(3, 3, 3), DOWN, 0);
    send(5, 1, 1, pos(1, 1, 0), EAST, 0);
    send(1, 1, 1, pos(1, 1, 0), WEST, 0);
    down_faulty = 1'b0;
    idle(6);
    send(5, 1, 1, pos(1, 1, 0), DOWN, 0);
    drain("drain_down_fault");

    // A 3-cycle up fault pulse is filtered out.
    up_faulty = 1'b1;
    idle(3);
    up_faulty = 1'b0;
    idle(2);
    send(2, 1, 1, pos(1, 1, 3), UP, 0);

    // Held fault: head accepted on the 4th edge still sees the old level.
    up_faulty = 1'b1;
    idle(3);
    send(2, 1, 1, pos(1, 1, 3), UP,    0);
    send(2, 1, 1, pos(1, 1, 3), EAST,  0);
    send(1, 1, 1, pos(1, 1, 3), WEST,  0);
    send(2, 1, 1, pos(3, 1, 3), EAST,  0);
    send(2, 1, 1, pos(1, 0, 3), SOUTH, 0);
    drain("drain_up_fault");

    // Adaptive X/Y choice driven by LFSR bit 2.
    count_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ep = m_lfsr[2] ? NORTH : EAST;
      send(2, 1, 1, pos(2, 3, 3), ep, 0);
    end
    drain("drain_adaptive");
    count_en = 1'b0;
    chk("adaptive_total", east_cnt + north_cnt, 1000);
    chk("adaptive_ratio_40_60", int'(east_cnt >= 400 && east_cnt <= 600), 1);
    up_faulty = 1'b0;
    idle(6);

    // Backpressure: result holds, input blocked, queued flit delivered afterwards.
    send(2, 1, 1, pos(3, 1, 1), EAST, 0);
    rt_ready[2] = 1'b0;
    fork
      send(2, 1, 1, pos(1, 3, 1), NORTH, 0);
    join_none
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_rt_valid", int'(rt_valid[2]), 1);
      chk("stall_in_ready", int'(in_ready[2]), 0);
      chk("stall_rt_port", int'(rt_port[2]), int'(EAST));
      @(negedge clk);
    end
    rt_ready[2] = 1'b1;
    idle(3);
    drain("drain_stall");

    // Reset mid-packet abandons the packet.
    send(5, 1, 0, pos(1, 1, 0), DOWN, 0);
    rst_n = 1'b0;
    sb.delete();
    err_model = '0;
    #1;
    chk("rst_mid_rt_valid", int'(rt_valid), 0);
    chk("rst_mid_rt_err", int'(rt_err), 0);
    chk("rst_mid_rt_tail", int'(rt_tail), 0);
    chk("rst_mid_rt_port", int'(rt_port[5]), int'(DROP));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(5, 0, 0, pos(1, 1, 0), DROP, 1);
    drain("drain_post_reset");
    chk("post_reset_err_sticky", int'(rt_err[5]), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
